// File: rtl/m_counter_pkg.sv
// Shared constants and parameter checks for the up/down modulo counter family.
// Pure declarations; no logic and no flow control.
package m_counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int MAX_WIDTH = 16;

  // Minimum register width able to hold the values 0..n-1.
  function automatic int bits_needed(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit modulus_legal(input int width, input int modulus);
    return (width >= 1) && (width <= MAX_WIDTH) &&
           (modulus >= 2) && (bits_needed(modulus) <= width);
  endfunction

endpackage

// File: rtl/m_counter_tc.sv
// Terminal-state decoder: TS = Q at the last value in the current count direction.
// Combinational, zero latency; down compare exists only with COUNTER_UPDN_DOWN_EN.
module m_counter_tc
  import m_counter_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] Q_MAX = '1
) (
  input  logic [WIDTH-1:0] q,
  input  logic             ud,
  output logic             ts
);

`ifdef COUNTER_UPDN_DOWN_EN
  assign ts = (ud == DIR_UP) ? (q == Q_MAX) : (q == '0);
`else
  logic unused_ud;
  assign unused_ud = ud;
  assign ts        = (q == Q_MAX);
`endif

endmodule

// File: rtl/m_counter_updn_mod.sv
// Cascadable modulo-MODULUS counter with sync load, P/T enables, comb CO, registered WRAP.
// Q and WRAP update one edge after load/count; COUNTER_UPDN_DOWN_EN enables the down direction.
module m_counter_updn_mod
  import m_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             LD,
  input  logic             CT_P,
  input  logic             CT_T,
  input  logic             UD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             WRAP
);

  if (!modulus_legal(WIDTH, MODULUS)) begin : g_bad_param
    $error("m_counter_updn_mod: MODULUS=%0d is illegal for WIDTH=%0d", MODULUS, WIDTH);
  end

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_r;
  logic             wrap_nxt;
  logic             ts;
  logic             count_en;
  logic             load_ok;

  m_counter_tc #(
    .WIDTH (WIDTH),
    .Q_MAX (Q_MAX)
  ) u_tc (
    .q  (q_r),
    .ud (UD),
    .ts (ts)
  );

  assign count_en = CT_P & CT_T;
  // Out-of-range load data clears rather than truncates, so Q never leaves 0..MODULUS-1.
  assign load_ok  = ({1'b0, D} < MOD_EXT);

  always_comb begin
    q_nxt    = q_r;
    wrap_nxt = 1'b0;
    if (!LD) begin
      q_nxt = load_ok ? D : '0;
    end else if (count_en) begin
      wrap_nxt = ts;
`ifdef COUNTER_UPDN_DOWN_EN
      if (UD == DIR_DN) begin
        q_nxt = ts ? Q_MAX : q_r - 1'b1;
      end else begin
        q_nxt = ts ? '0 : q_r + 1'b1;
      end
`else
      q_nxt = ts ? '0 : q_r + 1'b1;
`endif
    end
  end

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      wrap_r <= wrap_nxt;
    end
  end

  assign Q    = q_r;
  assign WRAP = wrap_r;
  assign CO   = CR & CT_T & ts;

endmodule
